clk_div_gen: RTL and testbench

//  Parametrised, runtime-reprogrammable fabric clock generator. It derives NUM_CH divided

---
 rtl/clk_div_gen.sv | 172 +++++++++++++++++
 tb/tb_clk_div_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// Runtime-reprogrammable divided-clock generator: NUM_CH registered outputs from refclk,
// each with its own divisor and phase, plus a lock flag that drops across every reconfiguration.
module clk_div_gen #(
    parameter int                        NUM_CH      = 3,
    parameter int                        DIV_W       = 8,
    parameter int                        LOCK_CYCLES = 16,
    parameter logic [NUM_CH*DIV_W-1:0]   DEF_DIVS    = {8'd2, 8'd4, 8'd2},
    parameter int                        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_stb,
    output logic              locked,
    output logic [1:0]        dbg_state
);

    localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ALIGN  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LCK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0]    cnt_q   [NUM_CH];
    logic [DIV_W-1:0]    cnt_d   [NUM_CH];
    logic [DIV_W-1:0]    div_q   [NUM_CH];
    logic [DIV_W-1:0]    div_d   [NUM_CH];
    logic [DIV_W-1:0]    phase_q [NUM_CH];
    logic [DIV_W-1:0]    phase_d [NUM_CH];
    logic [CH_W-1:0]     shd_ch_q, shd_ch_d;
    logic [DIV_W-1:0]    shd_div_q, shd_div_d;
    logic [DIV_W-1:0]    shd_phase_q, shd_phase_d;
    logic [NUM_CH-1:0]   outclk_q, outclk_d;
    logic [NUM_CH-1:0]   stb_q, stb_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic wr_ok;
    logic wr_accept;
    logic drain_hit;
    logic lock_done;

    function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] d);
        return (d >> 1) + {{(DIV_W-1){1'b0}}, d[0]};
    endfunction

    always_comb begin
        wr_ok     = (int'(cfg_ch) < NUM_CH) && (cfg_div >= DIV_W'(2)) && (cfg_phase < cfg_div);
        wr_accept = cfg_wr && (state_q == ST_RUN) && wr_ok;
        lock_done = (lock_cnt_q == LCK_W'(LOCK_CYCLES - 1));
        drain_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (shd_ch_q == CH_W'(i) && cnt_q[i] == div_q[i] - DIV_W'(1)) drain_hit = 1'b1;
        end
    end

    // State register
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_SETTLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (wr_accept) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_hit) state_d = ST_ALIGN;
            ST_ALIGN:  state_d = ST_SETTLE;
            ST_SETTLE: if (lock_done) state_d = ST_RUN;
            default:   state_d = ST_SETTLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cfg_ready = (state_q == ST_RUN);
        dbg_state = state_q;
    end

    // Datapath: counters, committed config, shadow, registered outputs
    always_comb begin
        lock_cnt_d  = '0;
        shd_ch_d    = shd_ch_q;
        shd_div_d   = shd_div_q;
        shd_phase_d = shd_phase_q;
        locked_d    = locked_q;
        err_d       = cfg_wr && (state_q == ST_RUN) && !wr_ok;
        outclk_d    = '0;
        stb_d       = '0;

        if (state_q == ST_SETTLE && !lock_done) lock_cnt_d = lock_cnt_q + LCK_W'(1);
        if (state_q == ST_SETTLE && lock_done)  locked_d = 1'b1;
        if (wr_accept) begin
            locked_d    = 1'b0;
            shd_ch_d    = cfg_ch;
            shd_div_d   = cfg_div;
            shd_phase_d = cfg_phase;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]   = div_q[i];
            phase_d[i] = phase_q[i];
            if (state_q == ST_DRAIN && drain_hit && shd_ch_q == CH_W'(i)) begin
                div_d[i]   = shd_div_q;
                phase_d[i] = shd_phase_q;
            end

            // ALIGN reloads so the channel rises phase_q cycles after a zero-phase one
            if (state_q == ST_ALIGN)
                cnt_d[i] = (phase_q[i] == '0) ? '0 : div_q[i] - phase_q[i];
            else if (cnt_q[i] >= div_q[i] - DIV_W'(1))
                cnt_d[i] = '0;
            else
                cnt_d[i] = cnt_q[i] + DIV_W'(1);

            if (state_q != ST_ALIGN) begin
                outclk_d[i] = (cnt_q[i] < half_up(div_q[i]));
                stb_d[i]    = (cnt_q[i] == '0);
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q  <= '0;
            shd_ch_q    <= '0;
            shd_div_q   <= '0;
            shd_phase_q <= '0;
            outclk_q    <= '0;
            stb_q       <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                div_q[i]   <= DEF_DIVS[i*DIV_W +: DIV_W];
                phase_q[i] <= '0;
            end
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            shd_ch_q    <= shd_ch_d;
            shd_div_q   <= shd_div_d;
            shd_phase_q <= shd_phase_d;
            outclk_q    <= outclk_d;
            stb_q       <= stb_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
                phase_q[i] <= phase_d[i];
            end
        end
    end

    assign outclk     = outclk_q;
    assign outclk_stb = stb_q;
    assign locked     = locked_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: a timeline model (per-channel origin/offset arithmetic and
// reconfiguration event cycles) checked against the DUT on every cycle.
module tb_clk_div_gen;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int L      = 16;
    localparam int CH_W   = 2;

    localparam int S_RUN = 0, S_DRAIN = 1, S_ALIGN = 2, S_SETTLE = 3;

    logic              refclk = 1'b0;
    logic              rst_n  = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outclk_stb;
    logic              locked;
    logic [1:0]        dbg_state;

    clk_div_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(L), .DEF_DIVS({8'd2, 8'd4, 8'd2})
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_ready(cfg_ready),
        .cfg_err(cfg_err), .outclk(outclk), .outclk_stb(outclk_stb),
        .locked(locked), .dbg_state(dbg_state)
    );

    always #5 refclk = ~refclk;

    int n_pass = 0;
    int n_total = 0;

    // Model: cycle c is the interval after rising edge c (cycle 0 follows reset release).
    // Channel count in cycle t is (t - base + off) mod D.
    int c;
    int dm[NUM_CH], pm[NUM_CH], bm[NUM_CH], km[NUM_CH];
    int run_from, drain_start, drain_end, align_c, err_at;
    bit pend;
    int pend_ch, pend_d, pend_p;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    endtask

    function automatic int cnt_at(input int i, input int t);
        return ((t - bm[i]) + km[i]) % dm[i];
    endfunction

    function automatic int state_at(input int t);
        if (t >= run_from) return S_RUN;
        if (t == align_c) return S_ALIGN;
        if (t >= drain_start && t <= drain_end) return S_DRAIN;
        return S_SETTLE;
    endfunction

    task automatic model_reset();
        c = 0;
        dm[0] = 2; dm[1] = 4; dm[2] = 2;
        for (int i = 0; i < NUM_CH; i++) begin
            pm[i] = 0; bm[i] = 0; km[i] = 0;
        end
        run_from = L; drain_start = -10; drain_end = -10; align_c = -10; err_at = -10;
        pend = 0;
    endtask

    task automatic apply_pending();
        dm[pend_ch] = pend_d;
        pm[pend_ch] = pend_p;
        for (int i = 0; i < NUM_CH; i++) begin
            bm[i] = align_c + 1;
            km[i] = (dm[i] - pm[i]) % dm[i];
        end
        pend = 0;
    endtask

    task automatic model_write(input int ch, input int dv, input int ph);
        int d;
        if (state_at(c) != S_RUN) return;
        if (ch >= NUM_CH || dv < 2 || ph >= dv) begin
            err_at = c + 1;
            return;
        end
        d = -1;
        for (int t = c + 1; t < c + 1 + 300; t++) begin
            if (cnt_at(ch, t) == dm[ch] - 1) begin
                d = t;
                break;
            end
        end
        pend = 1; pend_ch = ch; pend_d = dv; pend_p = ph;
        drain_start = c + 1; drain_end = d; align_c = d + 1; run_from = d + 2 + L;
    endtask

    task automatic check_cycle();
        logic [NUM_CH-1:0] eo, es;
        int st;
        eo = '0; es = '0;
        if (c - 1 != align_c) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int v;
                v = cnt_at(i, c - 1);
                eo[i] = (v < (dm[i] + 1) / 2);
                es[i] = (v == 0);
            end
        end
        st = state_at(c);
        chk("outclk", int'(outclk), int'(eo));
        chk("outclk_stb", int'(outclk_stb), int'(es));
        chk("locked", int'(locked), int'(st == S_RUN));
        chk("cfg_ready", int'(cfg_ready), int'(st == S_RUN));
        chk("cfg_err", int'(cfg_err), int'(c == err_at));
    endtask

    task automatic step(input bit wr, input int ch, input int dv, input int ph);
        @(negedge refclk);
        c++;
        if (pend && c - 1 >= align_c + 1) apply_pending();
        check_cycle();
        cfg_wr    = wr;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        if (wr) model_write(ch, dv, ph);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    task automatic wait_run();
        int k;
        k = 0;
        while (state_at(c) != S_RUN && k < 400) begin
            step(0, 0, 0, 0);
            k++;
        end
        if (k >= 400) chk("wait_run_timeout", 1, 0);
    endtask

    task automatic release_reset();
        @(negedge refclk);
        rst_n = 1'b1;
        cfg_wr = 1'b0;
        model_reset();
    endtask

    // Hand-derived values after reset with defaults {2,4,2}
    task automatic default_literals();
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, 0);
            if (c == 1) begin
                chk("lit_c1_outclk", int'(outclk), 3'b111);
                chk("lit_c1_stb", int'(outclk_stb), 3'b111);
            end
            if (c == 2) begin
                chk("lit_c2_outclk", int'(outclk), 3'b010);
                chk("lit_c2_stb", int'(outclk_stb), 3'b000);
            end
            if (c == 3) chk("lit_c3_outclk", int'(outclk), 3'b101);
            if (c == 15) chk("lit_c15_locked", int'(locked), 0);
            if (c == 16) chk("lit_c16_locked", int'(locked), 1);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) begin
            @(negedge refclk);
            chk("rst_outclk", int'(outclk), 0);
            chk("rst_stb", int'(outclk_stb), 0);
            chk("rst_locked", int'(locked), 0);
            chk("rst_ready", int'(cfg_ready), 0);
            chk("rst_err", int'(cfg_err), 0);
        end
        release_reset();
        default_literals();
        idle(5);

        // Reprogram ch1 to 5, then ch2 to D=4 P=1 next to ch1 D=4 P=0
        wait_run();
        step(1, 1, 5, 0);
        idle(4);
        wait_run();
        idle(12);
        step(1, 1, 4, 0);
        wait_run();
        step(1, 2, 4, 1);
        wait_run();
        idle(20);

        // Rejected writes
        step(1, 3, 4, 0);
        step(0, 0, 0, 0);
        chk("lit_err_pulse", int'(cfg_err), 1);
        step(1, 0, 1, 0);
        step(1, 1, 4, 4);
        idle(10);

        // Write during SETTLE is ignored
        step(1, 0, 3, 0);
        while (state_at(c) != S_SETTLE) step(0, 0, 0, 0);
        step(1, 0, 7, 3);
        step(1, 5 % 4, 2, 5);
        wait_run();
        idle(20);

        // Randomized writes, valid and invalid mixed
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 15) == 0)
                step(1, $urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 10));
            else
                step(0, 0, 0, 0);
        end
        wait_run();

        // Reset in the middle of DRAIN
        step(1, 0, 9, 2);
        step(0, 0, 0, 0);
        chk("drain_ready_low", int'(cfg_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_outclk", int'(outclk), 0);
        chk("midrst_stb", int'(outclk_stb), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_ready", int'(cfg_ready), 0);
        release_reset();
        default_literals();
        idle(30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
